// File: rtl/reg_writeback_ctrl_pkg.sv
// Shared register-file constants and the write-source encoding used by
// the writeback controller.
package reg_writeback_ctrl_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef enum logic {
    WB_SRC_ALU = 1'b0,
    WB_SRC_MEM = 1'b1
  } wb_src_e;

endpackage

// File: rtl/reg_writeback_ctrl_if.sv
// Bundle of the ALU, load, issue, query and register-file write signals.
// The master modport is the writeback controller; slave is its environment.
interface reg_writeback_ctrl_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);

  logic              issue_valid;
  logic [ADDR_W-1:0] issue_addr;
  logic              alu_valid;
  logic [ADDR_W-1:0] alu_addr;
  logic [DATA_W-1:0] alu_data;
  logic              mem_valid;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic              mem_ready;
  logic              rf_write_en;
  logic [ADDR_W-1:0] rf_write_addr;
  logic [DATA_W-1:0] rf_write_data;
  logic [ADDR_W-1:0] query_addr_0;
  logic [ADDR_W-1:0] query_addr_1;
  logic              busy_0;
  logic              busy_1;

  modport master (
    input  issue_valid, issue_addr,
    input  alu_valid, alu_addr, alu_data,
    input  mem_valid, mem_addr, mem_data,
    output mem_ready,
    output rf_write_en, rf_write_addr, rf_write_data,
    input  query_addr_0, query_addr_1,
    output busy_0, busy_1
  );

  modport slave (
    output issue_valid, issue_addr,
    output alu_valid, alu_addr, alu_data,
    output mem_valid, mem_addr, mem_data,
    input  mem_ready,
    input  rf_write_en, rf_write_addr, rf_write_data,
    output query_addr_0, query_addr_1,
    input  busy_0, busy_1
  );

endinterface

// File: rtl/reg_writeback_ctrl_wb_fifo.sv
// Synchronous FIFO holding load results that lost write-port arbitration.
// Synchronous active-low reset; push while full is honoured only with a pop.
module wb_fifo #(
  parameter int WIDTH = 37,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       pop_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == (PTR_W+1)'(DEPTH));
  assign empty    = (count == '0);
  assign pop_data = mem[rd_ptr];

  always_comb begin
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset: occupancy alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (rst && do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/reg_writeback_ctrl.sv
// Register-file write-port arbiter: ALU first, then buffered loads in order,
// then a direct load; tracks registers awaiting load results for decode.
module reg_writeback_ctrl
  import reg_writeback_ctrl_pkg::*;
#(
  parameter int DATA_W     = REG_DATA_W,
  parameter int ADDR_W     = REG_ADDR_W,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  reg_writeback_ctrl_if.master bus
);

  localparam int NREG    = 1 << ADDR_W;
  localparam int ENTRY_W = ADDR_W + DATA_W;
  localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
  localparam logic [ADDR_W-1:0] ZERO = ADDR_W'(REG_ZERO);

  logic               alu_sel;
  logic               load_accept;
  logic               load_keep;
  logic               fifo_push;
  logic               fifo_pop;
  logic               fifo_full;
  logic               fifo_empty;
  logic [CNT_W-1:0]   fifo_count;
  logic [ENTRY_W-1:0] fifo_head;
  logic               sel_en;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_data;
  wb_src_e            sel_src;
  wb_src_e            wr_src;
  logic [NREG-1:0]    pending;
  logic [NREG-1:0]    pending_next;

  assign bus.mem_ready = rst && (fifo_count != CNT_W'(FIFO_DEPTH));

  wb_fifo #(
    .WIDTH(ENTRY_W),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (fifo_push),
    .push_data({bus.mem_addr, bus.mem_data}),
    .pop      (fifo_pop),
    .pop_data (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  // Loads to r0 complete the handshake but never reach the buffer or port.
  always_comb begin
    alu_sel     = bus.alu_valid && (bus.alu_addr != ZERO);
    load_accept = bus.mem_valid && bus.mem_ready;
    load_keep   = load_accept && (bus.mem_addr != ZERO);
    fifo_push   = 1'b0;
    fifo_pop    = 1'b0;
    sel_en      = 1'b0;
    sel_addr    = bus.alu_addr;
    sel_data    = bus.alu_data;
    sel_src     = WB_SRC_ALU;
    if (alu_sel) begin
      sel_en    = 1'b1;
      fifo_push = load_keep && !fifo_full;
    end else if (!fifo_empty) begin
      fifo_pop             = 1'b1;
      sel_en               = 1'b1;
      {sel_addr, sel_data} = fifo_head;
      sel_src              = WB_SRC_MEM;
      fifo_push            = load_keep;
    end else if (load_keep) begin
      sel_en   = 1'b1;
      sel_addr = bus.mem_addr;
      sel_data = bus.mem_data;
      sel_src  = WB_SRC_MEM;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      bus.rf_write_en   <= 1'b0;
      bus.rf_write_addr <= '0;
      bus.rf_write_data <= '0;
      wr_src            <= WB_SRC_ALU;
    end else begin
      bus.rf_write_en <= sel_en;
      if (sel_en) begin
        bus.rf_write_addr <= sel_addr;
        bus.rf_write_data <= sel_data;
        wr_src            <= sel_src;
      end
    end
  end

  // Set is applied after clear so a same-edge reissue keeps the register busy.
  always_comb begin
    pending_next = pending;
    if (bus.rf_write_en && (wr_src == WB_SRC_MEM))
      pending_next[bus.rf_write_addr] = 1'b0;
    if (bus.issue_valid && (bus.issue_addr != ZERO))
      pending_next[bus.issue_addr] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) pending <= '0;
    else      pending <= pending_next;
  end

  assign bus.busy_0 = pending[bus.query_addr_0] && (bus.query_addr_0 != ZERO);
  assign bus.busy_1 = pending[bus.query_addr_1] && (bus.query_addr_1 != ZERO);

endmodule

// File: tb/tb_reg_writeback_ctrl.sv
// Self-checking bench: directed vector table followed by random traffic,
// all compared against a queue-based model of the writeback rules.
module tb_reg_writeback_ctrl;

  localparam int DEPTH = 4;

  typedef struct {
    logic        rst;
    logic        iv;
    logic [4:0]  ia;
    logic        av;
    logic [4:0]  aa;
    logic [31:0] ad;
    logic        mv;
    logic [4:0]  ma;
    logic [31:0] md;
    logic [4:0]  q0;
    logic [4:0]  q1;
    logic        e_en;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
    logic        e_ready;
    logic        e_b0;
    logic        e_b1;
  } vec_t;

  logic clk;
  logic rst;
  int   tests;
  int   fails;

  reg_writeback_ctrl_if #(.DATA_W(32), .ADDR_W(5)) bus ();

  reg_writeback_ctrl #(
    .DATA_W(32),
    .ADDR_W(5),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [36:0] mq [$];
  logic [31:0] m_pend;
  logic        m_en;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  logic        m_src;

  function automatic vec_t mk(input logic r, input logic iv, input logic [4:0] ia,
                              input logic av, input logic [4:0] aa, input logic [31:0] ad,
                              input logic mv, input logic [4:0] ma, input logic [31:0] md,
                              input logic [4:0] q0, input logic [4:0] q1,
                              input logic en, input logic [4:0] ea, input logic [31:0] ed,
                              input logic rdy, input logic b0, input logic b1);
    vec_t v;
    v.rst = r;  v.iv = iv; v.ia = ia; v.av = av; v.aa = aa; v.ad = ad;
    v.mv = mv;  v.ma = ma; v.md = md; v.q0 = q0; v.q1 = q1;
    v.e_en = en; v.e_addr = ea; v.e_data = ed; v.e_ready = rdy;
    v.e_b0 = b0; v.e_b1 = b1;
    return v;
  endfunction

  // Model of the writeback rules: loads wait in a plain queue behind the ALU.
  task automatic model_step(input vec_t v);
    logic        lok;
    logic [36:0] e;
    if (!v.rst) begin
      mq.delete();
      m_pend = '0;
      m_en = 1'b0; m_addr = '0; m_data = '0; m_src = 1'b0;
    end else begin
      lok = v.mv && (mq.size() < DEPTH) && (v.ma != 5'd0);
      if (m_en && m_src) m_pend[m_addr] = 1'b0;
      if (v.iv && v.ia != 5'd0) m_pend[v.ia] = 1'b1;
      if (v.av && v.aa != 5'd0) begin
        m_en = 1'b1; m_addr = v.aa; m_data = v.ad; m_src = 1'b0;
        if (lok) mq.push_back({v.ma, v.md});
      end else if (mq.size() > 0) begin
        e = mq.pop_front();
        m_en = 1'b1; {m_addr, m_data} = e; m_src = 1'b1;
        if (lok) mq.push_back({v.ma, v.md});
      end else if (lok) begin
        m_en = 1'b1; m_addr = v.ma; m_data = v.md; m_src = 1'b1;
      end else begin
        m_en = 1'b0;
      end
    end
  endtask

  task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("[TB] FAIL %s at %0t: got %h, want %h", name, $time, got, want);
    end
  endtask

  task automatic apply_stimulus(input vec_t v, input bit use_table);
    rst              = v.rst;
    bus.issue_valid  = v.iv;
    bus.issue_addr   = v.ia;
    bus.alu_valid    = v.av;
    bus.alu_addr     = v.aa;
    bus.alu_data     = v.ad;
    bus.mem_valid    = v.mv;
    bus.mem_addr     = v.ma;
    bus.mem_data     = v.md;
    bus.query_addr_0 = v.q0;
    bus.query_addr_1 = v.q1;
    @(posedge clk);
    #1;
    model_step(v);
    check_output("model_en",    32'(bus.rf_write_en), 32'(m_en));
    check_output("model_addr",  32'(bus.rf_write_addr), 32'(m_addr));
    check_output("model_data",  bus.rf_write_data, m_data);
    check_output("model_ready", 32'(bus.mem_ready), 32'(v.rst && (mq.size() < DEPTH)));
    check_output("model_busy0", 32'(bus.busy_0), 32'(m_pend[v.q0] && v.q0 != 5'd0));
    check_output("model_busy1", 32'(bus.busy_1), 32'(m_pend[v.q1] && v.q1 != 5'd0));
    check_output("no_r0_write", 32'(bus.rf_write_en && bus.rf_write_addr == 5'd0), 32'd0);
    if (use_table) begin
      check_output("tbl_en",    32'(bus.rf_write_en), 32'(v.e_en));
      check_output("tbl_addr",  32'(bus.rf_write_addr), 32'(v.e_addr));
      check_output("tbl_data",  bus.rf_write_data, v.e_data);
      check_output("tbl_ready", 32'(bus.mem_ready), 32'(v.e_ready));
      check_output("tbl_busy0", 32'(bus.busy_0), 32'(v.e_b0));
      check_output("tbl_busy1", 32'(bus.busy_1), 32'(v.e_b1));
    end
  endtask

  vec_t tbl [$];
  vec_t rv;

  initial begin
    tests = 0;
    fails = 0;

    tbl.push_back(mk(0, 0,0, 0,0,0, 0,0,0, 7,3, 0,0,0, 0,0,0));
    for (int i = 0; i < 10; i++)
      tbl.push_back(mk(1, 0,0, 0,0,0, 0,0,0, 7,3, 0,0,0, 1,0,0));
    tbl.push_back(mk(1, 0,0, 1,3,32'h1234, 0,0,0, 7,3, 1,3,32'h1234, 1,0,0));
    tbl.push_back(mk(1, 0,0, 0,0,0, 0,0,0, 7,3, 0,3,32'h1234, 1,0,0));
    // Load to r7: busy from issue until the cycle after its write.
    tbl.push_back(mk(1, 1,7, 0,0,0, 0,0,0, 7,3, 0,3,32'h1234, 1,1,0));
    tbl.push_back(mk(1, 0,0, 0,0,0, 0,0,0, 7,3, 0,3,32'h1234, 1,1,0));
    tbl.push_back(mk(1, 0,0, 0,0,0, 0,0,0, 7,3, 0,3,32'h1234, 1,1,0));
    tbl.push_back(mk(1, 0,0, 0,0,0, 1,7,32'hCAFE, 7,3, 1,7,32'hCAFE, 1,1,0));
    tbl.push_back(mk(1, 0,0, 0,0,0, 0,0,0, 7,3, 0,7,32'hCAFE, 1,0,0));
    // ALU hogs the port while r8..r11 fill the buffer.
    for (int i = 0; i < 6; i++)
      tbl.push_back(mk(1, 0,0, 1,5'(i+1),32'hA0+i, (i < 4),5'(8+i),32'h808+i, 0,0,
                       1,5'(i+1),32'hA0+i, (i < 3),0,0));
    for (int k = 0; k < 4; k++)
      tbl.push_back(mk(1, 0,0, 0,0,0, 0,0,0, 0,0, 1,5'(8+k),32'h808+k, 1,0,0));
    tbl.push_back(mk(1, 0,0, 0,0,0, 0,0,0, 0,0, 0,11,32'h80B, 1,0,0));
    tbl.push_back(mk(1, 0,0, 1,0,32'hDEAD, 1,5,32'h55, 0,0, 1,5,32'h55, 1,0,0));
    tbl.push_back(mk(1, 0,0, 0,0,0, 0,0,0, 0,0, 0,5,32'h55, 1,0,0));
    tbl.push_back(mk(1, 1,0, 0,0,0, 1,0,32'h77, 0,0, 0,5,32'h55, 1,0,0));
    // Reset lands while two buffered loads are draining.
    tbl.push_back(mk(1, 1,9, 0,0,0, 0,0,0, 9,10, 0,5,32'h55, 1,1,0));
    tbl.push_back(mk(1, 1,10, 0,0,0, 0,0,0, 9,10, 0,5,32'h55, 1,1,1));
    tbl.push_back(mk(1, 0,0, 1,1,32'h11, 1,9,32'h99, 9,10, 1,1,32'h11, 1,1,1));
    tbl.push_back(mk(1, 0,0, 1,2,32'h22, 1,10,32'hAA, 9,10, 1,2,32'h22, 1,1,1));
    tbl.push_back(mk(1, 0,0, 0,0,0, 0,0,0, 9,10, 1,9,32'h99, 1,1,1));
    tbl.push_back(mk(0, 0,0, 0,0,0, 0,0,0, 9,10, 0,0,0, 0,0,0));
    tbl.push_back(mk(1, 0,0, 0,0,0, 0,0,0, 9,10, 0,0,0, 1,0,0));
    tbl.push_back(mk(1, 0,0, 0,0,0, 0,0,0, 9,10, 0,0,0, 1,0,0));

    foreach (tbl[i]) apply_stimulus(tbl[i], 1'b1);

    for (int n = 0; n < 600; n++) begin
      rv = mk(($urandom_range(0, 63) != 0),
              ($urandom_range(0, 3) == 0), 5'($urandom),
              ($urandom_range(0, 1) == 1), 5'($urandom), $urandom,
              ($urandom_range(0, 1) == 1), 5'($urandom_range(0, 7)), $urandom,
              5'($urandom_range(0, 7)), 5'($urandom),
              0,0,0, 0,0,0);
      apply_stimulus(rv, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/reg_writeback_ctrl.md
Name: reg_writeback_ctrl

Overview:
- Initiator side of the CPU register-file write port.
- Collects destination writes from the single-cycle ALU path and the variable-latency memory/load path, arbitrates them onto the single register-file write port, and buffers load results that lose arbitration.
- Holds a per-register pending scoreboard so decode can stall reads of registers whose load result has not yet committed.

Parameters:
- DATA_W, 32, register data width
- ADDR_W, 5, register address width (32 registers, r0 hard-wired zero)
- FIFO_DEPTH, 4, load-result buffer entries (power of two, >=2)

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  synchronous, active-low reset (rst==0 at a rising edge resets)
- issue_valid  input  1  long-latency load issued this cycle; reserve issue_addr
- issue_addr  input  ADDR_W  destination register of issued load
- alu_valid  input  1  ALU result present (always accepted)
- alu_addr  input  ADDR_W  ALU destination
- alu_data  input  DATA_W  ALU result
- mem_valid  input  1  load result present
- mem_addr  input  ADDR_W  load destination
- mem_data  input  DATA_W  load result
- mem_ready  output  1  load result accepted when mem_valid && mem_ready
- rf_write_en  output  1  register-file write enable
- rf_write_addr  output  ADDR_W  register-file write address
- rf_write_data  output  DATA_W  register-file write data
- query_addr_0  input  ADDR_W  decode read address 0
- query_addr_1  input  ADDR_W  decode read address 1
- busy_0  output  1  query_addr_0 awaiting a load result
- busy_1  output  1  query_addr_1 awaiting a load result

Behaviour:
- Reset (rst==0 at an edge):
  - rf_write_en/addr/data = 0.
  - FIFO empty, pending[31:0] = 0.
  - All inputs ignored that cycle.
  - mem_ready forced 0 while rst==0; 1 on the first cycle after reset.
  - Reset mid-operation discards buffered load results and the in-flight write.
- Outputs rf_write_* are registered: a write selected in cycle k appears in cycle k+1 for exactly one cycle; the register file commits it at the end of k+1.
- Arbitration per cycle, ALU has absolute priority:
  - alu_valid && alu_addr!=0: select ALU. Any accepted load goes to the FIFO tail.
  - Else FIFO non-empty: pop head, select it. An accepted load the same cycle goes to the tail.
  - Else accepted load with mem_addr!=0: select it directly, bypassing the FIFO.
  - Else rf_write_en=0 next cycle. rf_write_addr/data hold their previous values.
- Load ordering is strictly preserved: a new load never overtakes a buffered one.
- mem_ready = !full, driven combinationally from the occupancy count. Push and pop in the same cycle are allowed when full only if a pop occurs; mem_ready still reports !full, so no same-cycle full bypass.
- Writes to r0:
  - ALU with alu_addr==0 is treated as no ALU request.
  - A load with mem_addr==0 is accepted (handshake completes) but dropped; it is never pushed or written.
  - issue_addr==0 never sets pending.
- Scoreboard:
  - pending[issue_addr] set at the edge when issue_valid.
  - pending[a] cleared at the edge ending the cycle where rf_write_en==1, rf_write_addr==a, and that write originated from the load path. Track source with one registered bit.
  - Same-edge set and clear of the same address: set wins.
  - ALU writes never modify pending.
  - busy_n = pending[query_addr_n], combinational; always 0 for address 0.
- Width: no arithmetic on data. FIFO pointers are log2(FIFO_DEPTH) bits with natural wrap. Count is log2(FIFO_DEPTH)+1 bits.

Decomposition:
- Shared cpu package holds:
  - REG_ADDR_W=5, REG_DATA_W=32, REG_ZERO=5'd0.
  - Write-source encoding (WB_SRC_ALU=0, WB_SRC_MEM=1).
- One sub-module, wb_fifo: synchronous FIFO with push/pop/full/empty/count and the same reset. Arbitration, scoreboard and output registers stay in reg_writeback_ctrl.

Test Plan:
- Reset then idle -> rf_write_en=0, rf_write_addr=0, mem_ready=1, busy_0=busy_1=0 for 10 cycles.
- alu_valid, addr=3, data=0x1234 in cycle k -> rf_write_en=1, addr=3, data=0x1234 in cycle k+1 only.
- issue_valid addr=7; 3 cycles later mem_valid addr=7 data=0xCAFE with no ALU traffic:
  - busy for query 7 is 1 from the cycle after issue.
  - The write appears 1 cycle after the load is accepted.
  - busy clears the following cycle.
- ALU valid every cycle for 6 cycles while loads to r8..r11 arrive back-to-back:
  - FIFO fills and mem_ready drops to 0 after 4 accepts.
  - After ALU stops, writes r8,r9,r10,r11 appear in order on consecutive cycles.
- alu_valid addr=0 concurrent with mem_valid addr=5 data=0x55 -> load bypasses: write r5=0x55 next cycle; no write to r0 ever.
- Two loads buffered, rst=0 for one cycle mid-drain -> no further rf_write_en, pending all 0, FIFO empty, mem_ready=1 after release.
